// File: rtl/elevator_pkg.sv
// Shared definitions for the 4-floor elevator controller and floor_counter.
// State codes, floor geometry and floor mask helpers.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10,
        DOOR_OPEN = 2'b11
    } elev_state_e;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] floor);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i == int'(floor));
        end
        return m;
    endfunction

    // Floors strictly above/below the given one; empty at the top/bottom, never wraps.
    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] floor);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i > int'(floor));
        end
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] floor);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i < int'(floor));
        end
        return m;
    endfunction

endpackage

// File: rtl/elevator_if.sv
// Request/position/status bundle between the elevator controller and its environment.
// The estop signal exists only when ELEV_ESTOP_EN is defined.
interface elevator_if;
    import elevator_pkg::*;

    logic [NUM_FLOORS-1:0] req_btn;
    logic [FLOOR_W-1:0]    curr_floor;
    logic [1:0]            current_state;
    logic [NUM_FLOORS-1:0] pending_req;
    logic                  door_open;

`ifdef ELEV_ESTOP_EN
    logic                  estop;

    modport master (
        output req_btn, curr_floor, estop,
        input  current_state, pending_req, door_open
    );
    modport slave (
        input  req_btn, curr_floor, estop,
        output current_state, pending_req, door_open
    );
`else
    modport master (
        output req_btn, curr_floor,
        input  current_state, pending_req, door_open
    );
    modport slave (
        input  req_btn, curr_floor,
        output current_state, pending_req, door_open
    );
`endif

endinterface

// File: rtl/elevator_req_latch.sv
// Outstanding-request register with floor clear, plus above/below/here decode
// relative to the car's current floor.
module elevator_req_latch
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] req_btn,
    input  logic [FLOOR_W-1:0]    curr_floor,
    input  logic                  clr_here,
    input  logic                  in_door,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  above,
    output logic                  below,
    output logic                  here
);

    logic [NUM_FLOORS-1:0] pending_r;
    logic [NUM_FLOORS-1:0] here_mask_s;
    logic [NUM_FLOORS-1:0] set_s;
    logic [NUM_FLOORS-1:0] clr_s;
    logic [NUM_FLOORS-1:0] next_s;

    // Next pending set: a press at the open-door floor only extends the dwell, and clear beats set.
    always_comb begin
        here_mask_s = floor_onehot(curr_floor);
        if (in_door) begin
            set_s = req_btn & ~here_mask_s;
        end else begin
            set_s = req_btn;
        end
        if (clr_here) begin
            clr_s = here_mask_s;
        end else begin
            clr_s = {NUM_FLOORS{1'b0}};
        end
        next_s = (pending_r | set_s) & ~clr_s;
    end

    // Pending request register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {NUM_FLOORS{1'b0}};
        end else begin
            pending_r <= next_s;
        end
    end

    assign pending = pending_r;
    assign above   = |(pending_r & above_mask(curr_floor));
    assign below   = |(pending_r & below_mask(curr_floor));
    assign here    = pending_r[curr_floor];

endmodule

// File: rtl/elevator_fsm.sv
// Elevator motion controller: SCAN direction choice, motion commands and door dwell timer.
// Optional ELEV_ESTOP_EN adds the estop input (halts motion, freezes the door timer).
module elevator_fsm
    import elevator_pkg::*;
#(
    parameter int DOOR_TIME = 20,
    parameter int DOOR_W    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    elevator_if.slave  bus
);

    localparam logic [DOOR_W-1:0]  DOOR_LAST    = DOOR_W'(DOOR_TIME - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = {FLOOR_W{1'b0}};

    elev_state_e           state_r;
    logic [DOOR_W-1:0]     timer_r;
    logic                  dir_up_r;
    logic                  door_open_r;

    logic [NUM_FLOORS-1:0] pending_s;
    logic                  above_s;
    logic                  below_s;
    logic                  here_s;
    logic                  estop_s;
    logic                  in_door_s;
    logic                  enter_door_s;
    logic                  here_req_s;

`ifdef ELEV_ESTOP_EN
    assign estop_s = bus.estop;
`else
    assign estop_s = 1'b0;
`endif

    // Every non-door state opens the door first when the current floor is requested.
    always_comb begin
        in_door_s  = (state_r == DOOR_OPEN);
        here_req_s = bus.req_btn[bus.curr_floor];
        if (!in_door_s && here_s && !estop_s) begin
            enter_door_s = 1'b1;
        end else begin
            enter_door_s = 1'b0;
        end
    end

    elevator_req_latch u_req_latch (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_btn    (bus.req_btn),
        .curr_floor (bus.curr_floor),
        .clr_here   (enter_door_s),
        .in_door    (in_door_s),
        .pending    (pending_s),
        .above      (above_s),
        .below      (below_s),
        .here       (here_s)
    );

    // Controller state, travel direction, door timer and registered door flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            timer_r     <= {DOOR_W{1'b0}};
            dir_up_r    <= 1'b1;
            door_open_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (estop_s) begin
                        state_r <= IDLE;
                    end else if (here_s) begin
                        state_r     <= DOOR_OPEN;
                        timer_r     <= {DOOR_W{1'b0}};
                        door_open_r <= 1'b1;
                    end else if (above_s && (dir_up_r || !below_s)) begin
                        state_r  <= MOVE_UP;
                        dir_up_r <= 1'b1;
                    end else if (below_s) begin
                        state_r  <= MOVE_DOWN;
                        dir_up_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MOVE_UP: begin
                    if (estop_s) begin
                        state_r <= IDLE;
                    end else if (here_s) begin
                        state_r     <= DOOR_OPEN;
                        timer_r     <= {DOOR_W{1'b0}};
                        door_open_r <= 1'b1;
                    end else if (bus.curr_floor == TOP_FLOOR) begin
                        state_r <= IDLE;
                    end else if (above_s) begin
                        state_r <= MOVE_UP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MOVE_DOWN: begin
                    if (estop_s) begin
                        state_r <= IDLE;
                    end else if (here_s) begin
                        state_r     <= DOOR_OPEN;
                        timer_r     <= {DOOR_W{1'b0}};
                        door_open_r <= 1'b1;
                    end else if (bus.curr_floor == BOTTOM_FLOOR) begin
                        state_r <= IDLE;
                    end else if (below_s) begin
                        state_r <= MOVE_DOWN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DOOR_OPEN: begin
                    // A press at this floor restarts the dwell; estop holds the door as is.
                    if (estop_s) begin
                        timer_r <= timer_r;
                    end else if (here_req_s) begin
                        timer_r <= {DOOR_W{1'b0}};
                    end else if (timer_r == DOOR_LAST) begin
                        state_r     <= IDLE;
                        door_open_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r + {{(DOOR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    door_open_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.current_state = state_r;
    assign bus.pending_req   = pending_s;
    assign bus.door_open     = door_open_r;

endmodule
